nrf_spi_sequencer: RTL and testbench
====================================

// Module: nrf_spi_sequencer
// PURPOSE
//  Hardware SPI master and transaction sequencer for the nRF24L01 radio. Replaces PIO bit-banging of
//  nrf_csn/sck/mosi/miso by the Nios. Runs one command byte plus 0..32 payload bytes per CSN frame,
//  returns STATUS and read bytes, times CE pulses and latches the active-low IRQ line.
// PARAMETERS
//  CLK_DIV       4    SCK half-period in clk_clk cycles (>=2; 50 MHz/(2*4) = 6.25 MHz SCK)
//  CSN_SETUP     2    cycles from CSN low to first SCK rise window
//  CSN_HOLD      2    cycles from last SCK fall to CSN high
//  CSN_GAP       4    minimum CSN-high cycles between frames
//  CE_PULSE_CYC  750  CE high cycles per ce_pulse (15 us @ 50 MHz)
// PORTS
//  clk_clk      in   1  system clock
//  reset_reset  in   1  asynchronous reset, active-high
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  high in IDLE only; a transfer occurs when valid&ready
//  cmd_byte     in   8  nRF command byte, e.g. W_REGISTER|addr or R_RX_PAYLOAD
//  cmd_len      in   6  payload byte count; values >32 clamp to 32
//  tx_data      in   8  payload byte to send (0xFF for reads)
//  tx_valid     in   1  tx_data available
//  tx_ready     out  1  one-cycle pulse: tx_data consumed
//  rx_data      out  8  received byte; first byte of each frame is STATUS
//  rx_valid     out  1  one-cycle pulse; no backpressure
//  busy         out  1  high whenever state != IDLE
//  ce_hold      in   1  level: force nrf_ce high (PRX listen)
//  ce_pulse     in   1  one-cycle strobe: start a CE pulse (PTX send)
//  irq_clear    in   1  clears irq_pending
//  irq_pending  out  1  sticky flag: set on falling edge of synchronised nrf_irq
//  nrf_ce/nrf_csn/nrf_sck/nrf_mosi  out  1  radio pins
//  nrf_miso/nrf_irq                 in   1  radio pins
// BEHAVIOUR
//  Reset values: nrf_csn=1, nrf_sck=0, nrf_mosi=0, nrf_ce=0, rx_data=0, rx_valid=0, tx_ready=0,
//   irq_pending=0, busy=0, state=IDLE. cmd_ready=1 after reset release.
//  FSM: IDLE -> SETUP -> SHIFT -> (LOAD -> SHIFT)* -> HOLD -> GAP -> IDLE.
//  - IDLE: on cmd_valid&cmd_ready latch cmd_byte and clamped length; next cycle CSN=0, enter SETUP.
//  - SETUP: CSN_SETUP cycles, then SHIFT with cmd_byte as the shift byte.
//  - SHIFT (SPI mode 0, MSB first): MOSI is valid while SCK is low for CLK_DIV cycles; SCK is high
//    for CLK_DIV cycles. MISO is sampled on the last high cycle. SCK falls and the next bit is driven.
//    Each byte takes 16*CLK_DIV cycles. After the 8th fall, rx_valid pulses with the assembled byte.
//  - LOAD: entered when bytes remain. If tx_valid=1, pulse tx_ready, load tx_data, return to SHIFT.
//    If tx_valid=0, wait with SCK=0 and CSN=0 held; the frame stays open indefinitely.
//  - HOLD: CSN_HOLD cycles, then CSN=1. GAP: CSN_GAP cycles, then IDLE.
//  - cmd_len=0: one byte only (STATUS returned, e.g. NOP 0xFF); tx_ready never pulses.
//  - cmd_valid is ignored when busy. The byte counter never wraps: 1+32 bytes maximum per frame.
//  CE: nrf_ce = ce_hold | (ce_cnt != 0). ce_pulse loads ce_cnt=CE_PULSE_CYC; a pulse during an active
//   pulse restarts the count. CE is independent of the SPI FSM.
//  IRQ: nrf_irq passes through a 2-FF synchroniser. A 1->0 transition of the synced value sets
//   irq_pending. irq_clear clears it. If set and clear occur in the same cycle, set wins.
//  Reset mid-frame: CSN rises asynchronously, SCK=0, the frame is aborted, and no rx_valid is issued.
// TESTING
//  1 cmd 0xFF len0, MISO model returns 0x0E -> one CSN-low frame, 8 SCK rises, rx 0x0E, no tx_ready.
//  2 cmd 0x20 len1, tx 0x0B -> MOSI bits 0x20,0x0B, 16 SCK rises, rx STATUS+1 byte, 2 rx_valid pulses.
//  3 cmd 0x61 len40, tx 0xFF -> clamped: 33 bytes, 264 SCK rises, 32 tx_ready, 33 rx_valid pulses.
//  4 tx_valid low 100 cycles before byte 2 -> CSN stays 0, SCK stays 0, then resumes; data intact.
//  5 ce_pulse, then again at cycle 300 -> nrf_ce high continuously for 300+750 cycles; ce_hold overrides.
//  6 nrf_irq falls -> irq_pending by cycle 3; irq_clear with a new fall in the same cycle -> stays 1.
//    Assert reset mid-byte -> CSN=1 immediately.

Source files
------------

// File: rtl/nrf_spi_sequencer.sv
// nrf_spi_sequencer: SPI mode-0 master and frame sequencer for the nRF24L01 radio,
// with CE pulse timing and a latched, synchronised IRQ flag.
module nrf_spi_sequencer #(
    parameter int CLK_DIV      = 4,
    parameter int CSN_SETUP    = 2,
    parameter int CSN_HOLD     = 2,
    parameter int CSN_GAP      = 4,
    parameter int CE_PULSE_CYC = 750
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic [5:0] cmd_len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       ce_hold,
    input  logic       ce_pulse,
    input  logic       irq_clear,
    output logic       irq_pending,
    output logic       nrf_ce,
    output logic       nrf_csn,
    output logic       nrf_sck,
    output logic       nrf_mosi,
    input  logic       nrf_miso,
    input  logic       nrf_irq
);
    localparam int CEW = $clog2(CE_PULSE_CYC + 1);
    localparam logic [7:0] L_DIV = 8'(CLK_DIV);
    localparam logic [7:0] L_PER = 8'(2 * CLK_DIV - 1);
    localparam logic [7:0] L_SET = 8'(CSN_SETUP - 1);
    localparam logic [7:0] L_HLD = 8'(CSN_HOLD - 1);
    localparam logic [7:0] L_GAP = 8'(CSN_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_LOAD, S_HOLD, S_GAP} state_t;

    state_t           r_state, w_next;
    logic [7:0]       r_cnt, r_sh, r_rx;
    logic [2:0]       r_bit;
    logic [5:0]       r_len, r_idx;
    logic             r_rxv;
    logic [CEW-1:0]   r_ce_cnt;
    logic [1:0]       r_sync;
    logic             r_irq_d, r_irqp;
    logic             w_accept, w_edge, w_byte_end, w_fall;

    assign w_accept   = (r_state == S_IDLE) && cmd_valid;
    // w_edge marks the last SCK-high cycle: sample MISO, then SCK falls
    assign w_edge     = (r_state == S_SHIFT) && (r_cnt == L_PER);
    assign w_byte_end = w_edge && (r_bit == 3'd7);
    assign w_fall     = r_irq_d & ~r_sync[1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = cmd_valid ? S_SETUP : S_IDLE;
            S_SETUP: w_next = (r_cnt == L_SET) ? S_SHIFT : S_SETUP;
            S_SHIFT: w_next = w_byte_end ? ((r_idx == r_len) ? S_HOLD : S_LOAD) : S_SHIFT;
            S_LOAD:  w_next = tx_valid ? S_SHIFT : S_LOAD;
            S_HOLD:  w_next = (r_cnt == L_HLD) ? S_GAP : S_HOLD;
            S_GAP:   w_next = (r_cnt == L_GAP) ? S_IDLE : S_GAP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_cnt    <= '0;
            r_sh     <= '0;
            r_rx     <= '0;
            r_bit    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_rxv    <= 1'b0;
            r_ce_cnt <= '0;
            r_sync   <= 2'b11;
            r_irq_d  <= 1'b1;
            r_irqp   <= 1'b0;
        end else begin
            r_rxv <= 1'b0;
            r_cnt <= (w_next != r_state || w_edge) ? 8'd0 : r_cnt + 8'd1;
            if (w_accept) begin
                r_sh  <= cmd_byte;
                r_len <= (cmd_len > 6'd32) ? 6'd32 : cmd_len;
                r_idx <= '0;
                r_bit <= '0;
            end
            if (w_edge) begin
                r_sh  <= {r_sh[6:0], nrf_miso};
                r_bit <= r_bit + 3'd1;
            end
            if (w_byte_end) begin
                r_rx  <= {r_sh[6:0], nrf_miso};
                r_rxv <= 1'b1;
                r_idx <= r_idx + 6'd1;
            end
            if (r_state == S_LOAD && tx_valid) r_sh <= tx_data;
            r_ce_cnt <= ce_pulse ? CEW'(CE_PULSE_CYC) : (r_ce_cnt != '0) ? r_ce_cnt - 1'b1 : r_ce_cnt;
            r_sync   <= {r_sync[0], nrf_irq};
            r_irq_d  <= r_sync[1];
            r_irqp   <= w_fall | (r_irqp & ~irq_clear);
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tx_ready    = (r_state == S_LOAD) && tx_valid;
    assign rx_data     = r_rx;
    assign rx_valid    = r_rxv;
    assign irq_pending = r_irqp;
    assign nrf_ce      = ce_hold | (r_ce_cnt != '0);
    assign nrf_csn     = (r_state == S_IDLE) || (r_state == S_GAP);
    assign nrf_sck     = (r_state == S_SHIFT) && (r_cnt >= L_DIV);
    assign nrf_mosi    = (r_state == S_SHIFT) && r_sh[7];
endmodule

// File: tb/tb_nrf_spi_sequencer.sv
// tb_nrf_spi_sequencer: directed frames against a byte-level nRF slave model,
// plus CE pulse timing, IRQ latching and mid-frame reset.
module tb_nrf_spi_sequencer;
    logic       clk_clk = 0, reset_reset = 1, cmd_valid = 0, tx_valid = 0;
    logic [7:0] cmd_byte = 0, tx_data = 0;
    logic [5:0] cmd_len = 0;
    logic       ce_hold = 0, ce_pulse = 0, irq_clear = 0, nrf_irq = 1;
    logic       cmd_ready, tx_ready, rx_valid, busy, irq_pending;
    logic       nrf_ce, nrf_csn, nrf_sck, nrf_mosi, nrf_miso;
    logic [7:0] rx_data;

    int tests = 0, fails = 0;
    int rises = 0, falls = 0, base = 0, rxn = 0, txn = 0, frames = 0, mosin = 0;
    int r0, f0, x0, m0, k0, n, bad, hi;
    logic [7:0] rx_q [256];
    logic [7:0] mosi_q [256];
    logic [7:0] mosi_sh = 0;

    nrf_spi_sequencer dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte), .cmd_len(cmd_len), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .ce_hold(ce_hold), .ce_pulse(ce_pulse), .irq_clear(irq_clear), .irq_pending(irq_pending),
        .nrf_ce(nrf_ce), .nrf_csn(nrf_csn), .nrf_sck(nrf_sck), .nrf_mosi(nrf_mosi),
        .nrf_miso(nrf_miso), .nrf_irq(nrf_irq)
    );

    always #5 clk_clk = ~clk_clk;

    // slave replies STATUS 0x0E, then 0xA0+k for payload byte k
    function automatic logic [7:0] resp(input int k);
        return (k == 0) ? 8'h0E : 8'(8'hA0 + k);
    endfunction
    function automatic logic miso_bit(input int i);
        logic [7:0] b;
        b = resp(i / 8);
        return b[7 - (i % 8)];
    endfunction
    assign nrf_miso = miso_bit(falls - base);

    always @(posedge nrf_sck) begin
        mosi_sh = {mosi_sh[6:0], nrf_mosi};
        rises++;
        if (rises % 8 == 0) begin
            mosi_q[mosin] = mosi_sh;
            mosin++;
        end
    end
    always @(negedge nrf_sck) falls++;
    always @(negedge nrf_csn) frames++;
    always @(negedge clk_clk) begin
        if (rx_valid) begin
            rx_q[rxn] = rx_data;
            rxn++;
        end
        if (tx_ready) txn++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        r0 = rises; f0 = frames; x0 = txn; m0 = mosin; k0 = rxn;
    endtask

    task automatic start(input logic [7:0] c, input logic [5:0] l);
        @(negedge clk_clk);
        base = falls;
        cmd_byte = c;
        cmd_len = l;
        cmd_valid = 1;
        @(negedge clk_clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input int lim);
        int c = 0;
        while (busy && c < lim) begin
            @(negedge clk_clk);
            c++;
        end
        check("frame_done", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_clk);
        check("rst_csn", nrf_csn, 1);
        check("rst_sck", nrf_sck, 0);
        check("rst_mosi", nrf_mosi, 0);
        check("rst_ce", nrf_ce, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_irq", irq_pending, 0);
        check("rst_busy", busy, 0);
        reset_reset = 0;
        @(negedge clk_clk);
        check("rst_cmd_ready", cmd_ready, 1);

        // NOP, no payload
        snap();
        start(8'hFF, 6'd0);
        check("t1_busy", busy, 1);
        check("t1_ready_busy", cmd_ready, 0);
        wait_idle(200);
        check("t1_frames", frames - f0, 1);
        check("t1_rises", rises - r0, 8);
        check("t1_rxn", rxn - k0, 1);
        check("t1_status", rx_q[k0], 8'h0E);
        check("t1_txn", txn - x0, 0);
        check("t1_mosi", mosi_q[m0], 8'hFF);

        // register write, one payload byte
        snap();
        tx_data = 8'h0B;
        tx_valid = 1;
        start(8'h20, 6'd1);
        wait_idle(400);
        check("t2_frames", frames - f0, 1);
        check("t2_rises", rises - r0, 16);
        check("t2_rxn", rxn - k0, 2);
        check("t2_status", rx_q[k0], 8'h0E);
        check("t2_rx1", rx_q[k0+1], 8'hA1);
        check("t2_txn", txn - x0, 1);
        check("t2_mosi0", mosi_q[m0], 8'h20);
        check("t2_mosi1", mosi_q[m0+1], 8'h0B);

        // length 40 clamps to 32 payload bytes
        snap();
        tx_data = 8'hFF;
        start(8'h61, 6'd40);
        wait_idle(4000);
        check("t3_frames", frames - f0, 1);
        check("t3_rises", rises - r0, 264);
        check("t3_txn", txn - x0, 32);
        check("t3_rxn", rxn - k0, 33);
        check("t3_rx_last", rx_q[k0+32], 8'hC0);
        check("t3_mosi0", mosi_q[m0], 8'h61);
        check("t3_mosi_last", mosi_q[m0+32], 8'hFF);

        // tx stall before first payload byte
        snap();
        tx_valid = 0;
        tx_data = 8'h5A;
        start(8'h22, 6'd2);
        n = 0;
        while (rxn == k0 && n < 200) begin
            @(negedge clk_clk);
            n++;
        end
        check("t4_status_seen", rxn - k0, 1);
        bad = 0;
        repeat (100) begin
            @(negedge clk_clk);
            if (nrf_csn !== 1'b0 || nrf_sck !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("t4_stall_hold", bad, 0);
        check("t4_stall_txn", txn - x0, 0);
        tx_valid = 1;
        #1;
        check("t4_tx_ready", tx_ready, 1);
        @(posedge clk_clk);
        #1 tx_data = 8'hC3;
        wait_idle(400);
        tx_valid = 0;
        check("t4_rises", rises - r0, 24);
        check("t4_txn", txn - x0, 2);
        check("t4_rx1", rx_q[k0+1], 8'hA1);
        check("t4_rx2", rx_q[k0+2], 8'hA2);
        check("t4_mosi0", mosi_q[m0], 8'h22);
        check("t4_mosi1", mosi_q[m0+1], 8'h5A);
        check("t4_mosi2", mosi_q[m0+2], 8'hC3);

        // CE pulse restarted 300 cycles in
        @(negedge clk_clk);
        ce_pulse = 1;
        hi = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk_clk);
            ce_pulse = (k == 299);
            if (nrf_ce) hi++;
        end
        check("t5_ce_cycles", hi, 1050);
        check("t5_ce_low", nrf_ce, 0);
        ce_hold = 1;
        #1;
        check("t5_ce_hold", nrf_ce, 1);
        ce_hold = 0;
        #1;
        check("t5_ce_release", nrf_ce, 0);

        // IRQ latch through the synchroniser
        @(negedge clk_clk);
        nrf_irq = 0;
        @(negedge clk_clk);
        @(negedge clk_clk);
        check("t6_irq_early", irq_pending, 0);
        @(negedge clk_clk);
        check("t6_irq_set", irq_pending, 1);
        irq_clear = 1;
        @(negedge clk_clk);
        irq_clear = 0;
        check("t6_irq_clear", irq_pending, 0);
        nrf_irq = 1;
        repeat (4) @(negedge clk_clk);
        check("t6_irq_rise", irq_pending, 0);
        nrf_irq = 0;
        @(negedge clk_clk);
        @(negedge clk_clk);
        irq_clear = 1;
        @(negedge clk_clk);
        irq_clear = 0;
        check("t6_set_wins", irq_pending, 1);

        // reset in the middle of a byte
        snap();
        start(8'hFF, 6'd0);
        n = 0;
        while (!nrf_sck && n < 100) begin
            @(negedge clk_clk);
            n++;
        end
        check("t7_sck_seen", nrf_sck, 1);
        @(negedge clk_clk);
        #2 reset_reset = 1;
        #1;
        check("t7_csn_async", nrf_csn, 1);
        check("t7_sck_async", nrf_sck, 0);
        check("t7_busy_async", busy, 0);
        repeat (3) @(negedge clk_clk);
        reset_reset = 0;
        repeat (40) @(negedge clk_clk);
        check("t7_no_rx", rxn - k0, 0);
        check("t7_cmd_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
